yadmc_req_launch: RTL and testbench

- clk0-domain request launcher that feeds the controller's flag synchronizer.
- Accepts one bus-side memory request and holds its address, data and control stable as a bundled-data word.
- After a settle delay, emits a single-cycle flag pulse toward the clk1 domain, then waits for the completion flag returned through a second synchronizer.
- Returns read data or an error to the requester, then accepts the next request.

---
 rtl/yadmc_pkg.sv | 12 +
 rtl/yadmc_req_launch_if.sv | 37 +++
 rtl/yadmc_req_hold.sv | 32 +++
 rtl/yadmc_req_launch.sv | 120 ++++++++++++
 tb/tb_yadmc_req_launch.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/yadmc_pkg.sv
// Shared state encodings and default widths for the yadmc request launcher.
package yadmc_pkg;
  localparam int DEF_ADR_W = 23;
  localparam int DEF_DAT_W = 32;
  localparam int DEF_SEL_W = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;
endpackage

// File: rtl/yadmc_req_launch_if.sv
// Request / response / bundled-data bus between requester, launcher and synchronizers.
interface yadmc_req_launch_if
  import yadmc_pkg::*;
#(
  parameter int ADR_W = DEF_ADR_W,
  parameter int DAT_W = DEF_DAT_W,
  parameter int SEL_W = DEF_SEL_W
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [ADR_W-1:0] req_adr;
  logic [DAT_W-1:0] req_dat;
  logic [SEL_W-1:0] req_sel;
  logic             rsp_valid;
  logic [DAT_W-1:0] rsp_dat;
  logic             rsp_err;
  logic             xfer_flag;
  logic             xfer_we;
  logic [ADR_W-1:0] xfer_adr;
  logic [DAT_W-1:0] xfer_dat;
  logic [SEL_W-1:0] xfer_sel;
  logic             done_flag;
  logic [DAT_W-1:0] done_dat;

  modport master (
    output req_valid, req_we, req_adr, req_dat, req_sel, done_flag, done_dat,
    input  req_ready, rsp_valid, rsp_dat, rsp_err,
           xfer_flag, xfer_we, xfer_adr, xfer_dat, xfer_sel
  );

  modport slave (
    input  req_valid, req_we, req_adr, req_dat, req_sel, done_flag, done_dat,
    output req_ready, rsp_valid, rsp_dat, rsp_err,
           xfer_flag, xfer_we, xfer_adr, xfer_dat, xfer_sel
  );
endinterface

// File: rtl/yadmc_req_hold.sv
// Bundled-data capture register: holds the accepted request until the next load.
module yadmc_req_hold #(
  parameter int ADR_W = 23,
  parameter int DAT_W = 32,
  parameter int SEL_W = 4
) (
  input  logic             clk0,
  input  logic             rst,
  input  logic             load,
  input  logic             we,
  input  logic [ADR_W-1:0] adr,
  input  logic [DAT_W-1:0] dat,
  input  logic [SEL_W-1:0] sel,
  output logic             q_we,
  output logic [ADR_W-1:0] q_adr,
  output logic [DAT_W-1:0] q_dat,
  output logic [SEL_W-1:0] q_sel
);
  always_ff @(posedge clk0) begin
    if (rst) begin
      q_we  <= 1'b0;
      q_adr <= '0;
      q_dat <= '0;
      q_sel <= '0;
    end else if (load) begin
      q_we  <= we;
      q_adr <= adr;
      q_dat <= dat;
      q_sel <= sel;
    end
  end
endmodule

// File: rtl/yadmc_req_launch.sv
// clk0-side request launcher: capture, settle, flag pulse, wait for completion.
// Optional completion timeout with drain state enabled by YADMC_REQ_TIMEOUT_EN.
module yadmc_req_launch
  import yadmc_pkg::*;
#(
  parameter int ADR_W   = DEF_ADR_W,
  parameter int DAT_W   = DEF_DAT_W,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk0,
  input  logic             rst,
  yadmc_req_launch_if.slave bus
);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  if (SETTLE < 1)  begin : g_bad_settle  $error("SETTLE must be >= 1");  end
  if (TIMEOUT < 2) begin : g_bad_timeout $error("TIMEOUT must be >= 2"); end

  logic [2:0]       state;
  logic [SW-1:0]    scnt;
  logic             accept;
  logic             rsp_valid_q;
  logic [DAT_W-1:0] rsp_dat_q;
  logic             xwe;
  logic [ADR_W-1:0] xadr;
  logic [DAT_W-1:0] xdat;
  logic [SEL_W-1:0] xsel;

  assign accept = (state == ST_IDLE) && bus.req_valid;

  yadmc_req_hold #(.ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W)) u_hold (
    .clk0 (clk0),
    .rst  (rst),
    .load (accept),
    .we   (bus.req_we),
    .adr  (bus.req_adr),
    .dat  (bus.req_dat),
    .sel  (bus.req_sel),
    .q_we (xwe),
    .q_adr(xadr),
    .q_dat(xdat),
    .q_sel(xsel)
  );

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.xfer_flag = (state == ST_ISSUE);
  assign bus.xfer_we   = xwe;
  assign bus.xfer_adr  = xadr;
  assign bus.xfer_dat  = xdat;
  assign bus.xfer_sel  = xsel;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_dat   = rsp_dat_q;

`ifdef YADMC_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic          rsp_err_q;
  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk0) begin
    if (rst) begin
      state       <= ST_IDLE;
      scnt        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
`ifdef YADMC_REQ_TIMEOUT_EN
      tcnt        <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
`ifdef YADMC_REQ_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
      case (state)
        ST_IDLE: if (accept) begin
          scnt  <= SW'(SETTLE - 1);
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (scnt == '0) state <= ST_ISSUE;
          else            scnt  <= scnt - 1'b1;
        end
        ST_ISSUE: begin
`ifdef YADMC_REQ_TIMEOUT_EN
          tcnt  <= '0;
`endif
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // completion takes priority over a coincident terminal count
          if (bus.done_flag) begin
            if (!xwe) rsp_dat_q <= bus.done_dat;
            rsp_valid_q <= 1'b1;
            state       <= ST_IDLE;
          end
`ifdef YADMC_REQ_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT - 1)) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state       <= ST_DRAIN;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
`ifdef YADMC_REQ_TIMEOUT_EN
        // swallow the late completion so it cannot pair with the next request
        ST_DRAIN: if (bus.done_flag) state <= ST_IDLE;
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_yadmc_req_launch.sv
// Scoreboard bench for yadmc_req_launch; the timeout cases build with YADMC_REQ_TIMEOUT_EN.
module tb_yadmc_req_launch;
  import yadmc_pkg::*;

`ifdef YADMC_REQ_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  typedef struct {
    logic [31:0] dat;
    logic        err;
    int          cyc;
    logic        ready;
  } rsp_exp_t;

  typedef struct {
    int          cyc;
    logic [22:0] adr;
  } flag_exp_t;

  logic clk0 = 1'b0;
  logic rst  = 1'b1;
  int   cyc  = 0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] rsp_model = '0;
  logic        prev_flag = 1'b0;

  rsp_exp_t  rsp_q[$];
  flag_exp_t flag_q[$];

  yadmc_req_launch_if bus();

  yadmc_req_launch #(.SETTLE(2), .TIMEOUT(TO)) dut (
    .clk0(clk0),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk0 = ~clk0;
  always @(posedge clk0) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // response scoreboard
  initial forever begin
    @(negedge clk0);
    if (!rst && bus.rsp_valid === 1'b1) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected_rsp_valid", 64'(cyc), 64'hFFFF_FFFF);
      end else begin
        rsp_exp_t e;
        e = rsp_q.pop_front();
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
        chk("rsp_dat", 64'(bus.rsp_dat), 64'(e.dat));
        chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
        chk("rsp_req_ready", 64'(bus.req_ready), 64'(e.ready));
      end
    end
  end

  // flag scoreboard
  initial forever begin
    @(negedge clk0);
    if (!rst && bus.xfer_flag === 1'b1) begin
      if (prev_flag) chk("flag_consecutive", 64'd1, 64'd0);
      if (flag_q.size() == 0) begin
        chk("unexpected_xfer_flag", 64'(cyc), 64'hFFFF_FFFF);
      end else begin
        flag_exp_t f;
        f = flag_q.pop_front();
        chk("flag_cycle", 64'(cyc), 64'(f.cyc));
        chk("flag_adr", 64'(bus.xfer_adr), 64'(f.adr));
      end
    end
    prev_flag = (bus.xfer_flag === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1);
  end

  // Caller is at #1 after a posedge with the DUT idle. Completion is returned d cycles after ISSUE.
  task automatic txn(input logic we, input logic [22:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input int d, input logic [31:0] ddat,
                     input bit stray, input bit hold);
    int t;
    t = cyc;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_adr   = adr;
    bus.req_dat   = dat;
    bus.req_sel   = sel;
    flag_q.push_back('{cyc: t + 3, adr: adr});
    if (!we) rsp_model = ddat;
    rsp_q.push_back('{dat: rsp_model, err: 1'b0, cyc: t + 4 + d, ready: 1'b1});
    @(posedge clk0); #1;
    if (hold) begin
      bus.req_adr = ~adr;
      bus.req_dat = ~dat;
      bus.req_we  = ~we;
    end else begin
      bus.req_valid = 1'b0;
    end
    if (stray) bus.done_flag = 1'b1;
    @(negedge clk0);
    chk("xfer_adr_held", 64'(bus.xfer_adr), 64'(adr));
    chk("xfer_dat_held", 64'(bus.xfer_dat), 64'(dat));
    chk("ready_low_settle", 64'(bus.req_ready), 64'd0);
    @(posedge clk0); #1;
    bus.done_flag = 1'b0;
    while (cyc < t + 3 + d) begin @(posedge clk0); #1; end
    bus.done_flag = 1'b1;
    bus.done_dat  = ddat;
    @(posedge clk0); #1;
    bus.done_flag = 1'b0;
    bus.done_dat  = 32'h5A5A_5A5A;
    chk("xfer_we_held", 64'(bus.xfer_we), 64'(we));
    chk("xfer_sel_held", 64'(bus.xfer_sel), 64'(sel));
  endtask

  initial begin
    int t;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_adr   = '0;
    bus.req_dat   = '0;
    bus.req_sel   = '0;
    bus.done_flag = 1'b0;
    bus.done_dat  = '0;

    // 1. reset
    repeat (3) @(posedge clk0);
    #1 rst = 1'b0;
    @(negedge clk0);
    chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
    chk("reset_xfer_flag", 64'(bus.xfer_flag), 64'd0);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("reset_xfer_adr", 64'(bus.xfer_adr), 64'd0);
    @(posedge clk0); #1;

    // 2. write, done 7 cycles after ISSUE (T+10), response T+11
    txn(1'b1, 23'h12345, 32'hDEADBEEF, 4'hF, 7, 32'h1111_1111, 1'b0, 1'b0);
    // 3. read, starts in the same cycle as the previous response
    txn(1'b0, 23'h00400, 32'h0, 4'h3, 3, 32'hCAFEF00D, 1'b0, 1'b0);
    // write keeps the previous read data on rsp_dat
    txn(1'b1, 23'h7FFFF, 32'h0BAD_F00D, 4'h1, 2, 32'h2222_2222, 1'b0, 1'b0);

    // 4. req_valid held high, stray done_flag during SETTLE
    txn(1'b0, 23'h00010, 32'h0, 4'hF, 1, 32'hA5A5_0001, 1'b1, 1'b1);
    txn(1'b1, 23'h00020, 32'h1234_5678, 4'hC, 2, 32'hA5A5_0002, 1'b1, 1'b1);
    txn(1'b0, 23'h00030, 32'h0, 4'h5, 5, 32'hA5A5_0003, 1'b1, 1'b0);

    // stray done_flag while idle
    bus.done_flag = 1'b1;
    @(posedge clk0); #1 bus.done_flag = 1'b0;
    repeat (2) @(posedge clk0); #1;

    // 5. reset while in WAIT, then a late completion
    t = cyc;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_adr = 23'h055AA; bus.req_sel = 4'hF;
    flag_q.push_back('{cyc: t + 3, adr: 23'h055AA});
    @(posedge clk0); #1 bus.req_valid = 1'b0;
    while (cyc < t + 6) begin @(posedge clk0); #1; end
    rst = 1'b1;
    repeat (2) @(posedge clk0); #1;
    rst = 1'b0;
    rsp_model = '0;
    @(negedge clk0);
    chk("midrst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("midrst_xfer_adr", 64'(bus.xfer_adr), 64'd0);
    chk("midrst_rsp_dat", 64'(bus.rsp_dat), 64'd0);
    @(posedge clk0); #1;
    bus.done_flag = 1'b1; bus.done_dat = 32'hBADD_BADD;
    @(posedge clk0); #1 bus.done_flag = 1'b0;
    repeat (2) @(posedge clk0); #1;
    txn(1'b0, 23'h00ABC, 32'h0, 4'hF, 4, 32'h600D_600D, 1'b0, 1'b0);

`ifdef YADMC_REQ_TIMEOUT_EN
    // 6. timeout: error response 17 cycles after ISSUE, then drain a late completion
    t = cyc;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_adr = 23'h0DEAD; bus.req_sel = 4'hF;
    flag_q.push_back('{cyc: t + 3, adr: 23'h0DEAD});
    rsp_q.push_back('{dat: rsp_model, err: 1'b1, cyc: t + 20, ready: 1'b0});
    @(posedge clk0); #1 bus.req_valid = 1'b0;
    while (cyc < t + 24) begin @(posedge clk0); #1; end
    @(negedge clk0);
    chk("drain_req_ready", 64'(bus.req_ready), 64'd0);
    #1;
    bus.done_flag = 1'b1; bus.done_dat = 32'hDEAD_0000;
    @(posedge clk0); #1 bus.done_flag = 1'b0;
    @(negedge clk0);
    chk("post_drain_req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk0); #1;
    // completion on the terminal-count cycle wins
    txn(1'b0, 23'h00BEE, 32'h0, 4'hF, 16, 32'hF00D_CAFE, 1'b0, 1'b0);
    txn(1'b0, 23'h00BEF, 32'h0, 4'hF, 15, 32'h1357_9BDF, 1'b0, 1'b0);
`endif

    repeat (4) @(posedge clk0);
    chk("rsp_queue_empty", 64'(rsp_q.size()), 64'd0);
    chk("flag_queue_empty", 64'(flag_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
